// File: rtl/fpnew_opgroup_result_fifo.sv
// fpnew_opgroup_result_fifo
//   Output buffer behind one opgroup block. Stores result, status, extension
//   bit and tag in a Depth-entry FIFO, ORs the status of every popped entry
//   into sticky IEEE flags and reports occupancy for flush / idle logic.
//   Optional zero-latency fall-through path: define FPNEW_RESULT_FIFO_BYPASS_EN.
module fpnew_opgroup_result_fifo #(
   parameter  int unsigned Width    = 32,
   parameter  int unsigned TagWidth = 1,
   parameter  int unsigned Depth    = 4,
   localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic [Width-1:0]    in_result_i,
   input  logic [4:0]          in_status_i,
   input  logic                in_ext_bit_i,
   input  logic [TagWidth-1:0] in_tag_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic [Width-1:0]    out_result_o,
   output logic [4:0]          out_status_o,
   output logic                out_ext_bit_o,
   output logic [TagWidth-1:0] out_tag_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   input  logic                clear_fflags_i,
   output logic [4:0]          fflags_o,
   output logic [CntWidth-1:0] count_o,
   output logic                busy_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
   localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

   typedef struct packed {
      logic [Width-1:0]    result;
      logic [4:0]          status;
      logic                ext_bit;
      logic [TagWidth-1:0] tag;
   } entry_t;

   entry_t              mem [Depth];
   entry_t              in_entry;
   entry_t              head_entry;
   entry_t              out_entry;
   logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic [4:0]          fflags_q, fflags_d;
   logic                full, empty;
   logic                push, pop;
   logic                fifo_write, fifo_read;

   // Pointers walk 0..Depth-1 and wrap, so Depth need not be a power of two.
   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
      return (ptr == LastPtr) ? '0 : ptr + 1'b1;
   endfunction

   assign in_entry   = '{result: in_result_i, status: in_status_i,
                         ext_bit: in_ext_bit_i, tag: in_tag_i};
   assign head_entry = mem[rd_ptr_q];

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);

   // Ready depends only on occupancy: a full FIFO refuses even if a pop is
   // happening, which keeps out_ready_i out of the in_ready_o path.
   assign in_ready_o = ~full;
   assign push       = in_valid_i & ~full;
   assign pop        = out_valid_o & out_ready_i;

`ifdef FPNEW_RESULT_FIFO_BYPASS_EN
   // Empty FIFO with valid input: present the input directly. If it is taken
   // in the same cycle it never touches storage.
   assign out_valid_o = ~empty | in_valid_i;
   assign out_entry   = empty ? in_entry : head_entry;
   assign fifo_write  = push & ~(empty & out_ready_i);
   assign fifo_read   = pop & ~empty;
`else
   assign out_valid_o = ~empty;
   assign out_entry   = head_entry;
   assign fifo_write  = push;
   assign fifo_read   = pop;
`endif

   assign out_result_o  = out_entry.result;
   assign out_status_o  = out_entry.status;
   assign out_ext_bit_o = out_entry.ext_bit;
   assign out_tag_o     = out_entry.tag;
   assign fflags_o      = fflags_q;
   assign count_o       = count_q;
   assign busy_o        = ~empty;

   // Next-state for pointers, occupancy and sticky flags; flush wins over push/pop.
   always_comb begin
      // NOTE: every output of this block is assigned a default first so that no
      // path leaves it unassigned and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      fflags_d = (clear_fflags_i ? 5'b0 : fflags_q) |
                 ((pop & ~flush_i) ? out_status_o : 5'b0);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (fifo_write) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (fifo_read)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({fifo_write, fifo_read})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fflags_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         fflags_q <= fflags_d;
      end
   end

   // Entry storage write.
   always_ff @(posedge clk_i) begin
      // NOTE: the storage array has no reset; entries are only observed while
      // count_q marks them valid, so clearing them would buy nothing.
      if (fifo_write && !flush_i) mem[wr_ptr_q] <= in_entry;
   end

   // Upstream must hold valid until the entry is accepted.
   in_valid_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (in_valid_i && !in_ready_o) |=> in_valid_i);

endmodule

// File: tb/tb_fpnew_opgroup_result_fifo.sv
// Self-checking bench for fpnew_opgroup_result_fifo: directed vector table,
// hand sequences for reset/bypass corners, and randomized traffic checked
// against a queue-based reference model.
module tb_fpnew_opgroup_result_fifo;

   localparam int W  = 32;
   localparam int TW = 3;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);

   logic          clk;
   logic          rst;
   logic          flush;
   logic [W-1:0]  in_result;
   logic [4:0]    in_status;
   logic          in_ext_bit;
   logic [TW-1:0] in_tag;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_result;
   logic [4:0]    out_status;
   logic          out_ext_bit;
   logic [TW-1:0] out_tag;
   logic          out_valid;
   logic          out_ready;
   logic          clear_fflags;
   logic [4:0]    fflags;
   logic [CW-1:0] count;
   logic          busy;

   int n_pass  = 0;
   int n_total = 0;

   fpnew_opgroup_result_fifo #(.Width(W), .TagWidth(TW), .Depth(D)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .in_result_i    (in_result),
      .in_status_i    (in_status),
      .in_ext_bit_i   (in_ext_bit),
      .in_tag_i       (in_tag),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .out_result_o   (out_result),
      .out_status_o   (out_status),
      .out_ext_bit_o  (out_ext_bit),
      .out_tag_o      (out_tag),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .clear_fflags_i (clear_fflags),
      .fflags_o       (fflags),
      .count_o        (count),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic fl, input logic v, input logic [TW-1:0] tag,
                        input logic [W-1:0] res, input logic [4:0] st,
                        input logic rdy, input logic clr);
      flush        = fl;
      in_valid     = v;
      in_tag       = tag;
      in_result    = res;
      in_status    = st;
      in_ext_bit   = tag[0];
      out_ready    = rdy;
      clear_fflags = clr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          fl, v;
      logic [TW-1:0] tag;
      logic [W-1:0]  res;
      logic [4:0]    st;
      logic          rdy, clr;
      logic          ov, ir;
      logic [CW-1:0] cnt;
      logic [TW-1:0] otag;
      logic [W-1:0]  ores;
      logic [4:0]    ff;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic fl, input logic v, input logic [TW-1:0] tag,
                               input logic [W-1:0] res, input logic [4:0] st,
                               input logic rdy, input logic clr, input logic ov,
                               input logic ir, input logic [CW-1:0] cnt,
                               input logic [TW-1:0] otag, input logic [W-1:0] ores,
                               input logic [4:0] ff);
      vec_t r;
      r.fl = fl; r.v = v; r.tag = tag; r.res = res; r.st = st; r.rdy = rdy; r.clr = clr;
      r.ov = ov; r.ir = ir; r.cnt = cnt; r.otag = otag; r.ores = ores; r.ff = ff;
      vecs.push_back(r);
   endfunction

   // Outputs listed per row are the values seen before that row's clock edge.
   function automatic void build_table();
      // in-order flow with 1-cycle latency
      add(0,1,1,32'h3F800000,5'b0,1,0, 0,1,0,0,32'h0,5'b0);
      add(0,1,2,32'h40000000,5'b0,1,0, 1,1,1,1,32'h3F800000,5'b0);
      add(0,1,3,32'h40400000,5'b0,1,0, 1,1,1,2,32'h40000000,5'b0);
      add(0,0,0,32'h0,5'b0,1,0,        1,1,1,3,32'h40400000,5'b0);
      add(0,0,0,32'h0,5'b0,1,0,        0,1,0,0,32'h0,5'b0);
      // fill to full, hold off, full+pop rejects push, wrap, drain
      add(0,1,0,32'h100,5'b0,0,0, 0,1,0,0,32'h0,5'b0);
      add(0,1,1,32'h101,5'b0,0,0, 1,1,1,0,32'h100,5'b0);
      add(0,1,2,32'h102,5'b0,0,0, 1,1,2,0,32'h100,5'b0);
      add(0,1,3,32'h103,5'b0,0,0, 1,1,3,0,32'h100,5'b0);
      add(0,1,4,32'h104,5'b0,0,0, 1,0,4,0,32'h100,5'b0);
      add(0,1,4,32'h104,5'b0,1,0, 1,0,4,0,32'h100,5'b0);
      add(0,1,4,32'h104,5'b0,0,0, 1,1,3,1,32'h101,5'b0);
      add(0,0,0,32'h0,5'b0,1,0,   1,0,4,1,32'h101,5'b0);
      add(0,0,0,32'h0,5'b0,1,0,   1,1,3,2,32'h102,5'b0);
      add(0,0,0,32'h0,5'b0,1,0,   1,1,2,3,32'h103,5'b0);
      add(0,0,0,32'h0,5'b0,1,0,   1,1,1,4,32'h104,5'b0);
      add(0,0,0,32'h0,5'b0,0,0,   0,1,0,0,32'h0,5'b0);
      // sticky flags, clear coinciding with a pop
      add(0,1,1,32'hA,5'b00001,0,0, 0,1,0,0,32'h0,5'b0);
      add(0,1,2,32'hB,5'b10000,0,0, 1,1,1,1,32'hA,5'b0);
      add(0,1,3,32'hC,5'b00100,0,0, 1,1,2,1,32'hA,5'b0);
      add(0,0,0,32'h0,5'b0,1,0,     1,1,3,1,32'hA,5'b0);
      add(0,0,0,32'h0,5'b0,1,0,     1,1,2,2,32'hB,5'b00001);
      add(0,0,0,32'h0,5'b0,1,1,     1,1,1,3,32'hC,5'b10001);
      add(0,0,0,32'h0,5'b0,0,0,     0,1,0,0,32'h0,5'b00100);
      // flush together with push and pop at count 3
      add(0,1,5,32'h15,5'b00010,0,0, 0,1,0,0,32'h0,5'b00100);
      add(0,1,6,32'h16,5'b00010,0,0, 1,1,1,5,32'h15,5'b00100);
      add(0,1,7,32'h17,5'b00010,0,0, 1,1,2,5,32'h15,5'b00100);
      add(1,1,1,32'h11,5'b01000,1,0, 1,1,3,5,32'h15,5'b00100);
      add(0,1,2,32'h12,5'b0,0,0,     0,1,0,0,32'h0,5'b00100);
      add(0,0,0,32'h0,5'b0,1,0,      1,1,1,2,32'h12,5'b00100);
      // clear without pop
      add(0,0,0,32'h0,5'b0,0,1,      0,1,0,0,32'h0,5'b00100);
      add(0,0,0,32'h0,5'b0,0,0,      0,1,0,0,32'h0,5'b0);
   endfunction

   task automatic apply_row(input vec_t r, input int idx);
      drive(r.fl, r.v, r.tag, r.res, r.st, r.rdy, r.clr);
      #1;
      check($sformatf("row%0d out_valid", idx), out_valid, r.ov);
      check($sformatf("row%0d in_ready", idx),  in_ready,  r.ir);
      check($sformatf("row%0d count", idx),     count,     r.cnt);
      check($sformatf("row%0d busy", idx),      busy,      r.cnt != 0);
      check($sformatf("row%0d fflags", idx),    fflags,    r.ff);
      if (r.ov) begin
         check($sformatf("row%0d out_tag", idx),    out_tag,    r.otag);
         check($sformatf("row%0d out_result", idx), out_result, r.ores);
      end
      next_cycle();
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [W-1:0]  res;
      logic [4:0]    st;
      logic          ext;
      logic [TW-1:0] tag;
   } ent_t;

   ent_t       q[$];
   logic [4:0] m_ff;

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, '0, '0, '0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_ff = '0;
   endtask

   task automatic random_run(input int cycles);
      logic hold = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         ent_t in_e, head;
         logic exp_ov, exp_ir, acc, popd, byp;
         if (!hold) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            in_result  = $urandom;
            in_status  = 5'($urandom);
            in_tag     = TW'($urandom);
            in_ext_bit = 1'($urandom);
         end
         out_ready    = ($urandom_range(0, 3) != 0) ^ (c[8] & c[7]);
         flush        = ($urandom_range(0, 49) == 0);
         clear_fflags = ($urandom_range(0, 19) == 0);
         #1;
         in_e = '{res: in_result, st: in_status, ext: in_ext_bit, tag: in_tag};
         byp = 1'b0;
`ifdef FPNEW_RESULT_FIFO_BYPASS_EN
         byp = (q.size() == 0) && in_valid;
`endif
         exp_ov = (q.size() != 0) || byp;
         exp_ir = (q.size() != D);
         head   = (q.size() != 0) ? q[0] : in_e;
         check("rnd out_valid", out_valid, exp_ov);
         check("rnd in_ready",  in_ready,  exp_ir);
         check("rnd count",     count,     q.size());
         check("rnd busy",      busy,      q.size() != 0);
         check("rnd fflags",    fflags,    m_ff);
         if (exp_ov) begin
            check("rnd out_result",  out_result,  head.res);
            check("rnd out_status",  out_status,  head.st);
            check("rnd out_ext_bit", out_ext_bit, head.ext);
            check("rnd out_tag",     out_tag,     head.tag);
         end
         acc  = in_valid && exp_ir;
         popd = exp_ov && out_ready;
         hold = in_valid && !acc;
         if (flush) begin
            q.delete();
            m_ff = clear_fflags ? 5'b0 : m_ff;
         end else begin
            m_ff = (clear_fflags ? 5'b0 : m_ff) | (popd ? head.st : 5'b0);
            if (popd && q.size() != 0) void'(q.pop_front());
            if (acc && !(byp && popd)) q.push_back(in_e);
         end
         next_cycle();
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, '0, '0, '0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 1'b0);
      check("reset in_ready",  in_ready,  1'b1);
      check("reset count",     count,     '0);
      check("reset busy",      busy,      1'b0);
      check("reset fflags",    fflags,    5'b0);
      rst = 1'b0;

`ifndef FPNEW_RESULT_FIFO_BYPASS_EN
      build_table();
      for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i], i);
`else
      // fall-through consume: same-cycle output, nothing stored
      drive(0, 1, 3'd7, 32'h77, 5'b00001, 1, 0);
      #1;
      check("byp out_valid", out_valid, 1'b1);
      check("byp out_tag",   out_tag,   3'd7);
      check("byp count",     count,     '0);
      next_cycle();
      drive(0, 0, '0, '0, '0, 0, 0);
      #1;
      check("byp count after", count,     '0);
      check("byp valid after", out_valid, 1'b0);
      check("byp fflags",      fflags,    5'b00001);
      // fall-through not taken: entry is stored
      drive(0, 1, 3'd6, 32'h66, 5'b0, 0, 0);
      #1;
      check("byp hold valid", out_valid, 1'b1);
      check("byp hold tag",   out_tag,   3'd6);
      next_cycle();
      drive(0, 0, '0, '0, '0, 0, 0);
      #1;
      check("byp stored count", count,   1);
      check("byp stored tag",   out_tag, 3'd6);
      next_cycle();
`endif

      do_reset();
      random_run(3000);

      // reset asserted mid-cycle with entries in flight
      do_reset();
      drive(0, 1, 3'd1, 32'h1, 5'b0, 0, 0);
      next_cycle();
      next_cycle();
      drive(0, 0, '0, '0, '0, 0, 0);
      #1;
      check("midrst count before", count, 2);
      #1;
      rst = 1'b1;
      #1;
      check("midrst count",     count,     '0);
      check("midrst out_valid", out_valid, 1'b0);
      check("midrst in_ready",  in_ready,  1'b1);
      check("midrst busy",      busy,      1'b0);
      next_cycle();
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
